// File: rtl/alu_seq.sv
// Sequencing front-end for the 8-bit ALU: 4x8 register file, IDLE/EXEC/WB sequencer, direct load port.
// Optional zero flag output compiled in with `define ALU_SEQ_ZFLAG_EN.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_addsub,
  output logic       alu_shift,
  input  logic [7:0] alu_out,
  output logic       done,
  output logic [7:0] result
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic       flag_z
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  logic [1:0] state;
  logic [1:0] opQ;
  logic [1:0] rdQ;
  logic [7:0] resQ;
  logic [7:0] rf [4];
  logic       accept;
  logic       ldTake;

  // Handshake readies decode from the state register only.
  assign instr_ready = (state == IDLE);
  assign ld_ready    = (state != WB);
  assign accept      = instr_valid & instr_ready;
  assign ldTake      = ld_valid & ld_ready;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // alu_a/alu_b double as the operand latches, so the ALU inputs only move on entry to EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opQ        <= 2'b00;
      rdQ        <= 2'b00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_addsub <= 1'b0;
      alu_shift  <= 1'b0;
      resQ       <= 8'h00;
    end else begin
      if (accept) begin
        opQ        <= instr[7:6];
        rdQ        <= instr[5:4];
        alu_a      <= rf[instr[3:2]];
        alu_b      <= rf[instr[1:0]];
        alu_addsub <= (instr[7:6] != OP_SUB);
        alu_shift  <= (instr[7:6] == OP_SHL);
      end
      if (state == EXEC) begin
        resQ <= (opQ == OP_MOV) ? alu_a : alu_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      result <= 8'h00;
    end else begin
      done <= (state == WB);
      if (state == WB) begin
        result <= resQ;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
    end else if (state == WB) begin
      flag_z <= (resQ == 8'h00);
    end
  end
`endif

  // NOTE: the register file is reset explicitly because software relies on r0..r3 reading 0x00 after reset.
  // Write-back and direct loads never collide: ld_ready is low in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (state == WB) begin
      rf[rdQ] <= resQ;
    end else if (ldTake) begin
      rf[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU stand-in, register-file model, directed and random instructions.
// Zero-flag checks are compiled in with `define ALU_SEQ_ZFLAG_EN.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_addsub;
  logic       alu_shift;
  logic [7:0] alu_out;
  logic       done;
  logic [7:0] result;
`ifdef ALU_SEQ_ZFLAG_EN
  logic       flag_z;
`endif

  // Corrupts the ALU output; used on MOV to prove the result bypasses alu_out.
  logic [7:0] aluGarble = 8'h00;

  int nChecks = 0;
  int nFail   = 0;
  logic [7:0] modelRf [4];

  alu_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_addsub(alu_addsub), .alu_shift(alu_shift),
    .alu_out(alu_out), .done(done), .result(result)
`ifdef ALU_SEQ_ZFLAG_EN
    , .flag_z(flag_z)
`endif
  );

  initial forever #5 clk = ~clk;

  // Combinational stand-in for ALU_n8.
  always_comb begin
    if (alu_shift)       alu_out = {alu_a[6:0], 1'b0} ^ aluGarble;
    else if (alu_addsub) alu_out = (alu_a + alu_b) ^ aluGarble;
    else                 alu_out = (alu_a - alu_b) ^ aluGarble;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expOf(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * 8'd2;
      default: return a;
    endcase
  endfunction

  task automatic loadReg(input logic [1:0] addr, input logic [7:0] data);
    check("ld_ready_idle", ld_ready, 1);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    modelRf[addr] = data;
  endtask

  // One full instruction; optional direct load in the accept cycle or in the WB cycle.
  task automatic runInstr(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input bit ldAccept, input bit ldWb,
                          input logic [1:0] ldA, input logic [7:0] ldD);
    logic [7:0] a, b, exp;
    a = modelRf[rs1];
    b = modelRf[rs2];
    exp = expOf(op, a, b);
    aluGarble = (op == 2'b11) ? 8'($urandom_range(1, 255)) : 8'h00;
    check("instr_ready_idle", instr_ready, 1);
    instr = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    if (ldAccept) begin
      ld_valid = 1'b1; ld_addr = ldA; ld_data = ldD;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ld_valid = 1'b0;
    if (ldAccept) modelRf[ldA] = ldD;
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_addsub", alu_addsub, (op != 2'b01));
    check("exec_shift", alu_shift, (op == 2'b10));
    check("exec_instr_ready", instr_ready, 0);
    check("exec_done", done, 0);
    @(posedge clk); #1;
    if (ldWb) begin
      ld_valid = 1'b1; ld_addr = ldA; ld_data = ldD;
    end
    check("wb_ld_ready", ld_ready, 0);
    check("wb_instr_ready", instr_ready, 0);
    check("wb_done", done, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    modelRf[rd] = exp;
    check("done_pulse", done, 1);
    check("result", result, exp);
    check("alu_a_hold", alu_a, a);
`ifdef ALU_SEQ_ZFLAG_EN
    check("flag_z", flag_z, (exp == 8'h00));
`endif
    aluGarble = 8'h00;
  endtask

  task automatic readReg(input logic [1:0] r);
    runInstr(2'b11, r, r, r, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) modelRf[i] = 8'h00;
  endtask

  initial begin
    instr_valid = 1'b0; instr = 8'h00;
    ld_valid = 1'b0; ld_addr = 2'd0; ld_data = 8'h00;
    applyReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 8'h00);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_addsub", alu_addsub, 0);
    check("rst_shift", alu_shift, 0);
`ifdef ALU_SEQ_ZFLAG_EN
    check("rst_flag_z", flag_z, 0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADD r2 = r0 + r1
    loadReg(2'd0, 8'h12);
    loadReg(2'd1, 8'h34);
    runInstr(2'b00, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);
    readReg(2'd2);

    // SUB to zero
    loadReg(2'd0, 8'h50);
    loadReg(2'd1, 8'h50);
    runInstr(2'b01, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);

    // SHL then MOV
    loadReg(2'd1, 8'h21);
    runInstr(2'b10, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00);
    runInstr(2'b11, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 2'd0, 8'h00);

    // Load collisions: rejected during WB, read-before-write at accept
    runInstr(2'b00, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 2'd3, 8'hEE);
    readReg(2'd3);
    runInstr(2'b00, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 2'd1, 8'h07);
    readReg(2'd1);
    readReg(2'd2);

    // Back-to-back: instr_valid held high with three queued instructions
    begin
      logic [7:0] list [3];
      logic [7:0] expQ [3];
      int accepts, dones, cyc, lastAcc;
      bit acc;
      for (int i = 0; i < 3; i++) begin
        logic [1:0] op, rd, s1, s2;
        op = 2'($urandom_range(0, 2));
        rd = 2'($urandom); s1 = 2'($urandom); s2 = 2'($urandom);
        list[i] = {op, rd, s1, s2};
        expQ[i] = expOf(op, modelRf[s1], modelRf[s2]);
        modelRf[rd] = expQ[i];
      end
      accepts = 0; dones = 0; cyc = 0; lastAcc = 0;
      instr = list[0];
      instr_valid = 1'b1;
      while (cyc < 20 && (accepts < 3 || dones < 3)) begin
        acc = instr_valid && instr_ready;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          if (accepts > 0) check("b2b_gap", cyc - lastAcc, 3);
          lastAcc = cyc;
          accepts++;
          if (accepts < 3) instr = list[accepts];
          else instr_valid = 1'b0;
        end
        if (done) begin
          if (dones < 3) check("b2b_result", result, expQ[dones]);
          dones++;
        end
      end
      instr_valid = 1'b0;
      check("b2b_accepts", accepts, 3);
      check("b2b_dones", dones, 3);
    end

    // Random instructions against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) loadReg(2'($urandom), 8'($urandom));
      runInstr(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               2'($urandom), 8'($urandom));
    end
    for (int r = 0; r < 4; r++) readReg(2'(r));

    // Reset during EXEC drops the instruction
    loadReg(2'd0, 8'h11);
    instr = {2'b00, 2'd1, 2'd0, 2'd0};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_exec_ready", instr_ready, 0);
    applyReset();
    check("mid_rst_instr_ready", instr_ready, 1);
    check("mid_rst_ld_ready", ld_ready, 1);
    check("mid_rst_alu_a", alu_a, 8'h00);
    check("mid_rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", done, 0);
      check("mid_rst_result", result, 8'h00);
    end
    for (int r = 0; r < 4; r++) readReg(2'(r));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing front-end for the 8-bit combinational ALU (ALU_n8). It holds a 4 x 8-bit register file and accepts 8-bit instructions over a valid/ready handshake. For each instruction it latches the operands, drives the ALU's A/B/AddSub/shift inputs, captures AluOut one cycle later and writes the result back. It sits directly upstream of the ALU and also consumes the ALU's output.

## Interface
Parameters:
- none (width fixed at 8 to match the ALU)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  8  [7:6] op (00 ADD, 01 SUB, 10 SHL, 11 MOV), [5:4] rd, [3:2] rs1, [1:0] rs2
- ld_valid  in  1  direct register-file write request
- ld_ready  out  1  direct write can be taken this cycle
- ld_addr  in  2  register index for the direct write
- ld_data  in  8  data for the direct write
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_addsub  out  1  to ALU AddSub (1 = add, 0 = subtract)
- alu_shift  out  1  to ALU shift (1 = A shifted left by one)
- alu_out  in  8  from ALU AluOut
- done  out  1  one-cycle pulse when a result is written back
- result  out  8  written-back value, valid while done is high and held afterwards

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: register op/rd, set a_q = rf[rs1], b_q = rf[rs2], go to EXEC.
- EXEC:
  - Drive alu_a = a_q and alu_b = b_q.
  - ADD: alu_addsub = 1, alu_shift = 0.
  - SUB: alu_addsub = 0, alu_shift = 0.
  - SHL: alu_addsub = 1, alu_shift = 1; b_q is ignored by the ALU.
  - MOV: ALU controls as for ADD, but the result comes from a_q, not alu_out.
  - At the end of EXEC: res_q = (op == MOV) ? a_q : alu_out. Go to WB.
- WB:
  - rf[rd] = res_q, result = res_q, done = 1. Go to IDLE.
- ALU inputs hold their last values outside EXEC and change only on entry to EXEC.
- Result arithmetic is whatever alu_out returns, including the ALU's own overflow handling. No re-computation inside this block.
- Direct write port:
  - ld_ready = (state != WB).
  - On ld_valid & ld_ready: rf[ld_addr] = ld_data at that edge.
- Simultaneous events:
  - Direct write in the same cycle an instruction is accepted: operands read the old contents (read-before-write).
  - rd == rs1 or rd == rs2: legal, no hazard, because the next instruction is only accepted after WB.
- Reset mid-operation: any in-flight instruction is dropped with no write-back and no done pulse.

## Timing
- Accept at edge N. EXEC spans N..N+1. done and register write at edge N+2. instr_ready high again from N+2.
- Throughput: one instruction per 3 cycles. Latency from accept to done: 2 cycles.
- The ALU has a full cycle (EXEC) from stable inputs to capture, so it has no same-cycle path to instr.
- Reset values:
  - state = IDLE, so instr_ready = 1 and ld_ready = 1.
  - rf[0..3] = 0x00.
  - alu_a = alu_b = 0x00, alu_addsub = 0, alu_shift = 0.
  - done = 0, result = 0x00.
  - flag_z = 0 (when compiled in).
- instr_ready and ld_ready decode from registered state only (no input-to-output combinational path).

## Configuration
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined:
  - Adds output port flag_z (1 bit).
  - flag_z is set at the WB edge to (res_q == 0x00) and holds until the next WB.
  - Reset value 0.
- Undefined:
  - Port flag_z and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset then direct writes: reset, load r0 = 0x12, r1 = 0x34; ADD rd = r2, rs1 = r0, rs2 = r1 -> alu_a = 0x12 and alu_b = 0x34 during EXEC; done two cycles after accept with result = 0x46; r2 = 0x46.
- SUB with zero flag: r0 = 0x50, r1 = 0x50, SUB rd = r3 -> alu_addsub = 0 in EXEC; result = 0x00; flag_z = 1 (with ALU_SEQ_ZFLAG_EN).
- SHL and MOV: r1 = 0x21, SHL rd = r1, rs1 = r1 -> alu_shift = 1, result = 0x42, r1 = 0x42. Then MOV rd = r0, rs1 = r1 -> result = 0x42 regardless of alu_out.
- Back-to-back handshake: instr_valid held high with 3 queued instructions -> exactly one accept every 3 cycles; instr_ready low in EXEC and WB; 3 done pulses.
- Load collision: ld_valid in the WB cycle -> ld_ready = 0 and no write. Load to rs1 in the accept cycle -> old operand value is used and the new value is stored.
- Reset mid-EXEC: assert rst during EXEC -> no done pulse, rf unchanged (all 0x00 after reset), instr_ready = 1 immediately.
